// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned DIGITS_INT     = 5;
  localparam int unsigned BCD_W          = 4 * DIGITS_INT;
  localparam int unsigned OUT_W          = 16;
  localparam bcd_digit_t  ADD3_THRESHOLD = 4'd5;
  localparam logic [15:0] BCD_MAX_4DIG   = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble corrector: adds 3 to any digit of 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t corrected
);

  assign corrected = (digit >= ADD3_THRESHOLD) ? bcd_digit_t'(digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional build macro BIN_TO_BCD_SATURATE_EN clamps the output to 9999 on overflow.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  decimal_nybble,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   count;
  logic               load;
  logic               shift_en;
  logic               finish;
  logic [OUT_W-1:0]   result;
  logic               result_ovf;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS_INT; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (bcd[4*g +: 4]),
      .corrected (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:    load     = start;
      SHIFT:   shift_en = 1'b1;
      DONE:    finish   = 1'b1;
      default: ;
    endcase
  end

  // Digit 4 only becomes non-zero for values of 10000 and above.
  assign result_ovf = (bcd[BCD_W-1 -: 4] != 4'd0);
`ifdef BIN_TO_BCD_SATURATE_EN
  assign result = result_ovf ? BCD_MAX_4DIG : bcd[OUT_W-1:0];
`else
  assign result = bcd[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg      <= '0;
      bcd            <= '0;
      count          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      decimal_nybble <= '0;
      overflow       <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      if (load) begin
        shift_reg <= bin;
        bcd       <= '0;
        count     <= CNT_W'(WIDTH);
      end else if (shift_en) begin
        bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        count     <= count - CNT_W'(1);
      end
      if (finish) begin
        done           <= 1'b1;
        decimal_nybble <= result;
        overflow       <= result_ovf;
      end
    end
  end

endmodule
